ram_arbiter: RTL and testbench

- Parametrised N-channel arbiter between pipeline stages and the single-port synchronous ram; successor to the two-channel read-only front end.
- Adds writes, a configurable channel count and widths, round-robin fairness and a fixed, parameterised RAM read latency.
- Each stage holds a request and receives a one-cycle ready pulse. The block owns the ram's address, write-enable and data-in pins.

---
 rtl/ram_arbiter.sv | 130 +++++++++++++
 tb/tb_ram_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// N-channel arbiter in front of a single-port synchronous RAM: one access at a time, round-robin grant.
// Define RAM_ARBITER_FIXED_PRIORITY_EN to make the lowest-index requester always win instead.
module ram_arbiter #(
    parameter int CHANNELS    = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int RAM_LATENCY = 2
) (
    input  logic                       ram_clk,
    input  logic                       rst,
    input  logic [CHANNELS-1:0]        ch_req,
    input  logic [CHANNELS-1:0]        ch_we,
    input  logic [CHANNELS*ADDR_W-1:0] ch_addr,
    input  logic [CHANNELS*DATA_W-1:0] ch_wdata,
    output logic [CHANNELS-1:0]        ch_ready,
    output logic [CHANNELS*DATA_W-1:0] ch_rdata,
    output logic                       ram_write_enable,
    output logic [ADDR_W-1:0]          ram_address,
    output logic [DATA_W-1:0]          ram_data_in,
    input  logic [DATA_W-1:0]          ram_data_out
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = $clog2(RAM_LATENCY + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] grant;
    logic [CNT_W-1:0] cnt;
    logic             is_read;
    logic             pick_valid;
    logic [IDX_W-1:0] pick;
    logic             capture;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [CHANNELS-1:0] v);
        lowest_set = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IDX_W'(i);
        end
    endfunction

`ifdef RAM_ARBITER_FIXED_PRIORITY_EN
    always_comb begin
        pick_valid = |ch_req;
        pick       = lowest_set(ch_req);
    end
`else
    logic [IDX_W-1:0]    ptr;
    logic [CHANNELS-1:0] at_or_after_ptr;

    // Requests at or above the pointer win first; otherwise wrap around to the lowest requester.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
        pick_valid = |ch_req;
        for (int i = 0; i < CHANNELS; i++) begin
            at_or_after_ptr[i] = (IDX_W'(i) >= ptr);
        end
        pick = (|(ch_req & at_or_after_ptr)) ? lowest_set(ch_req & at_or_after_ptr)
                                             : lowest_set(ch_req);
    end

    always_ff @(posedge ram_clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (state == ST_DONE) begin
            ptr <= (grant == IDX_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
        end
    end
`endif

    // NOTE: all clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge ram_clk or negedge rst) begin
        if (!rst) begin
            state            <= ST_IDLE;
            grant            <= '0;
            cnt              <= '0;
            is_read          <= 1'b0;
            ch_ready         <= '0;
            ram_write_enable <= 1'b0;
            ram_address      <= '0;
            ram_data_in      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ch_ready <= '0;
                    if (pick_valid) begin
                        grant            <= pick;
                        ram_address      <= ch_addr[pick*ADDR_W +: ADDR_W];
                        ram_data_in      <= ch_wdata[pick*DATA_W +: DATA_W];
                        ram_write_enable <= ch_we[pick];
                        is_read          <= ~ch_we[pick];
                        cnt              <= CNT_W'(RAM_LATENCY);
                        state            <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // The write strobe lives only in the first BUSY cycle; the address stays put.
                    ram_write_enable <= 1'b0;
                    cnt              <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        ch_ready[grant] <= 1'b1;
                        state           <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ch_ready <= '0;
                    state    <= ST_IDLE;
                end
                default: begin
                    ch_ready <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign capture = (state == ST_BUSY) && (cnt == CNT_W'(1)) && is_read;

    always_ff @(posedge ram_clk or negedge rst) begin
        if (!rst) begin
            ch_rdata <= '0;
        end else if (capture) begin
            ch_rdata[grant*DATA_W +: DATA_W] <= ram_data_out;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus random traffic against a
// transaction-level model (grant order, completion time, shadow memory).
module tb_ram_arbiter;

    localparam int CHANNELS    = 4;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 8;
    localparam int RAM_LATENCY = 3;
    localparam int PERIOD      = RAM_LATENCY + 2;

    logic                       ram_clk = 1'b0;
    logic                       rst     = 1'b0;
    logic [CHANNELS-1:0]        ch_req;
    logic [CHANNELS-1:0]        ch_we;
    logic [CHANNELS*ADDR_W-1:0] ch_addr;
    logic [CHANNELS*DATA_W-1:0] ch_wdata;
    logic [CHANNELS-1:0]        ch_ready;
    logic [CHANNELS*DATA_W-1:0] ch_rdata;
    logic                       ram_write_enable;
    logic [ADDR_W-1:0]          ram_address;
    logic [DATA_W-1:0]          ram_data_in;
    logic [DATA_W-1:0]          ram_data_out;

    ram_arbiter #(
        .CHANNELS(CHANNELS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LATENCY(RAM_LATENCY)
    ) dut (
        .ram_clk(ram_clk), .rst(rst),
        .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_ready(ch_ready), .ch_rdata(ch_rdata),
        .ram_write_enable(ram_write_enable), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    always #5 ram_clk = ~ram_clk;

    // RAM environment: preloaded with i*0x11, read data appears RAM_LATENCY edges after the address.
    logic [DATA_W-1:0] ram_mem  [0:255];
    logic [DATA_W-1:0] ram_pipe [0:RAM_LATENCY-2];
    bit                loaded = 1'b0;

    always @(posedge ram_clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= DATA_W'(i * 17);
            loaded <= 1'b1;
        end else if (ram_write_enable) begin
            ram_mem[ram_address[7:0]] <= ram_data_in;
        end
        ram_pipe[0] <= ram_mem[ram_address[7:0]];
        for (int k = 1; k < RAM_LATENCY - 1; k++) ram_pipe[k] <= ram_pipe[k-1];
    end
    assign ram_data_out = ram_pipe[RAM_LATENCY-2];

    // Reference model state
    int                edge_n;
    bit                act;
    int                g_ch, grant_edge, rdy_edge, free_edge, rr_ptr;
    bit                g_we;
    logic [DATA_W-1:0] g_rval;
    logic [DATA_W-1:0] shadow    [0:255];
    logic [DATA_W-1:0] exp_rdata [CHANNELS];
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_din;
    bit                keep      [CHANNELS];

    // Observations of the DUT used by scenario-level checks
    int ready_cnt [CHANNELS];
    int we_cnt, last_ready_edge, last_ready_ch, prev_ready_edge, prev_ready_ch;
    bit spacing_on, alternate_on;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        act       = 1'b0;
        rr_ptr    = 0;
        free_edge = 0;
        exp_addr  = '0;
        exp_din   = '0;
        for (int i = 0; i < CHANNELS; i++) exp_rdata[i] = '0;
    endtask

    function automatic int pick_channel();
`ifdef RAM_ARBITER_FIXED_PRIORITY_EN
        for (int k = 0; k < CHANNELS; k++) if (ch_req[k]) return k;
`else
        for (int k = 0; k < CHANNELS; k++) if (ch_req[(rr_ptr + k) % CHANNELS]) return (rr_ptr + k) % CHANNELS;
`endif
        return -1;
    endfunction

    // One access at a time: granted when free, done RAM_LATENCY edges later, free again two edges after that.
    task automatic model_edge();
        if (!rst) begin
            model_reset();
            return;
        end
        if (act && edge_n > rdy_edge) act = 1'b0;
        if (!act && edge_n >= free_edge && |ch_req) begin
            g_ch       = pick_channel();
            act        = 1'b1;
            grant_edge = edge_n;
            rdy_edge   = edge_n + RAM_LATENCY;
            free_edge  = rdy_edge + 2;
            g_we       = ch_we[g_ch];
            exp_addr   = ch_addr[g_ch*ADDR_W +: ADDR_W];
            exp_din    = ch_wdata[g_ch*DATA_W +: DATA_W];
            if (g_we) shadow[exp_addr[7:0]] = exp_din;
            else      g_rval = shadow[exp_addr[7:0]];
            rr_ptr     = (g_ch + 1) % CHANNELS;
        end
        if (act && edge_n == rdy_edge && !g_we) exp_rdata[g_ch] = g_rval;
    endtask

    task automatic check_outputs();
        logic [CHANNELS-1:0] exp_ready;
        int                  idx;
        exp_ready = (act && edge_n == rdy_edge) ? CHANNELS'(1 << g_ch) : '0;
        check("ch_ready", 64'(ch_ready), 64'(exp_ready));
        check("ram_write_enable", 64'(ram_write_enable), 64'(act && g_we && edge_n == grant_edge));
        check("ram_address", 64'(ram_address), 64'(exp_addr));
        check("ram_data_in", 64'(ram_data_in), 64'(exp_din));
        for (int i = 0; i < CHANNELS; i++)
            check($sformatf("ch_rdata[%0d]", i), 64'(ch_rdata[i*DATA_W +: DATA_W]), 64'(exp_rdata[i]));
        if (ram_write_enable === 1'b1) we_cnt++;
        if (ch_ready != '0) begin
            idx = -1;
            for (int i = 0; i < CHANNELS; i++) if (ch_ready[i]) begin idx = i; ready_cnt[i]++; end
            if (spacing_on && prev_ready_edge >= 0)
                check("ready_spacing", 64'(edge_n - prev_ready_edge), 64'(PERIOD));
            if (alternate_on && prev_ready_ch >= 0)
                check("rr_alternate", 64'(idx != prev_ready_ch), 64'd1);
            prev_ready_edge = edge_n;
            prev_ready_ch   = idx;
            last_ready_edge = edge_n;
            last_ready_ch   = idx;
        end
    endtask

    task automatic step();
        @(posedge ram_clk);
        edge_n++;
        model_edge();
        #1;
        check_outputs();
        // A requester lowers its request once its completion pulse is seen, unless it keeps streaming.
        if (act && edge_n == rdy_edge && !keep[g_ch]) ch_req[g_ch] = 1'b0;
    endtask

    task automatic set_req(input int c, input bit we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input bit k);
        ch_req[c]                    = 1'b1;
        ch_we[c]                     = we;
        ch_addr[c*ADDR_W +: ADDR_W]  = a;
        ch_wdata[c*DATA_W +: DATA_W] = d;
        keep[c]                      = k;
    endtask

    task automatic wait_grant(input int c, input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            step();
            if (act && g_ch == c && edge_n == grant_edge) seen = 1'b1;
        end
        if (!seen) check(tag, 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < CHANNELS; i++) keep[i] = 1'b0;
        repeat (CHANNELS * PERIOD + 4) step();
    endtask

    int c_snap, rd_grant;

    initial begin
        ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
        edge_n = 0; we_cnt = 0; last_ready_edge = -1; last_ready_ch = -1;
        prev_ready_edge = -1; prev_ready_ch = -1; spacing_on = 1'b0; alternate_on = 1'b0;
        for (int i = 0; i < 256; i++) shadow[i] = DATA_W'(i * 17);
        for (int i = 0; i < CHANNELS; i++) begin keep[i] = 1'b0; ready_cnt[i] = 0; end
        model_reset();

        // Reset, then 20 idle cycles with nothing requested
        repeat (3) step();
        rst = 1'b1;
        we_cnt = 0;
        repeat (20) step();
        check("idle_we_never_high", 64'(we_cnt), 64'd0);

        // Channel 0 write then read back of the same address
        we_cnt = 0;
        set_req(0, 1'b1, 16'h0010, 8'hA5, 1'b0);
        repeat (PERIOD + 2) step();
        check("write_we_one_cycle", 64'(we_cnt), 64'd1);
        set_req(0, 1'b0, 16'h0010, 8'h00, 1'b0);
        wait_grant(0, "read_grant_timeout");
        rd_grant = edge_n;
        repeat (PERIOD + 2) step();
        check("read_latency", 64'(last_ready_edge - rd_grant), 64'(RAM_LATENCY));
        check("read_back_a5", 64'(ch_rdata[0 +: DATA_W]), 64'hA5);

        // Channels 0 and 1 stream reads of preloaded 0x11 / 0x22
`ifndef RAM_ARBITER_FIXED_PRIORITY_EN
        alternate_on = 1'b1; prev_ready_ch = -1;
`endif
        set_req(0, 1'b0, 16'h0001, 8'h00, 1'b1);
        set_req(1, 1'b0, 16'h0002, 8'h00, 1'b1);
        repeat (4 * PERIOD + 2) step();
        drain();
        alternate_on = 1'b0;
        check("stream_rdata0", 64'(ch_rdata[0 +: DATA_W]), 64'h11);
        check("stream_rdata1", 64'(ch_rdata[DATA_W +: DATA_W]), 64'h22);

        // Channel 1 drops its request one cycle after being granted
        c_snap = ready_cnt[1];
        set_req(1, 1'b0, 16'h0003, 8'h00, 1'b0);
        wait_grant(1, "drop_grant_timeout");
        step();
        ch_req[1] = 1'b0;
        repeat (PERIOD + 4) step();
        check("drop_ready_once", 64'(ready_cnt[1] - c_snap), 64'd1);

        // All channels streaming: completions evenly spaced
        spacing_on = 1'b1; prev_ready_edge = -1;
        for (int i = 0; i < CHANNELS; i++) set_req(i, 1'b0, ADDR_W'(4 + i), 8'h00, 1'b1);
        repeat (3 * CHANNELS * PERIOD) step();
        spacing_on = 1'b0;
        drain();

`ifdef RAM_ARBITER_FIXED_PRIORITY_EN
        // Fixed priority: channel 1 waits as long as channel 0 keeps asking
        c_snap = ready_cnt[1];
        set_req(0, 1'b0, 16'h0001, 8'h00, 1'b1);
        set_req(1, 1'b0, 16'h0002, 8'h00, 1'b1);
        repeat (4 * PERIOD) step();
        check("fixed_ch1_starved", 64'(ready_cnt[1] - c_snap), 64'd0);
        keep[0] = 1'b0;
        repeat (3 * PERIOD + 4) step();
        check("fixed_ch1_served", 64'(ready_cnt[1] > c_snap), 64'd1);
        drain();
`endif

        // Random traffic; granted requests may be scrambled or withdrawn mid-flight
        for (int n = 0; n < 1500; n++) begin
            step();
            for (int i = 0; i < CHANNELS; i++) begin
                if (act && g_ch == i) begin
                    if ($urandom_range(0, 3) == 0) begin
                        ch_we[i]                     = 1'($urandom_range(0, 1));
                        ch_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'($urandom_range(0, 15));
                        ch_wdata[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                    end
                    if (edge_n == grant_edge && $urandom_range(0, 7) == 0) ch_req[i] = 1'b0;
                end else if (!ch_req[i] && $urandom_range(0, 3) == 0) begin
                    set_req(i, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)),
                            DATA_W'($urandom), 1'b0);
                end
            end
        end
        drain();

        // Reset asserted in the middle of a read: outputs clear at once, no completion pulse
        c_snap = ready_cnt[2];
        set_req(2, 1'b0, 16'h0005, 8'h00, 1'b0);
        wait_grant(2, "rst_grant_timeout");
        step();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_async_ready", 64'(ch_ready), 64'd0);
        check("rst_async_we", 64'(ram_write_enable), 64'd0);
        check("rst_async_addr", 64'(ram_address), 64'd0);
        check("rst_async_rdata", 64'(ch_rdata), 64'd0);
        ch_req = '0;
        repeat (3) step();
        rst = 1'b1;
        repeat (PERIOD + 4) step();
        check("rst_no_ready", 64'(ready_cnt[2] - c_snap), 64'd0);

        // After reset channel 0 has top priority again
        set_req(1, 1'b0, 16'h0002, 8'h00, 1'b0);
        set_req(0, 1'b0, 16'h0001, 8'h00, 1'b0);
        repeat (RAM_LATENCY + 1) step();
        check("ptr_reset_first", 64'(last_ready_ch), 64'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
